sap_microsequencer: RTL and testbench
=====================================

Name: sap_microsequencer

Overview:
- Ring-counter control sequencer for the SAP-1 datapath: program counter, MAR, RAM, IR, accumulator, B register, ALU and output register.
- Produces one control word per T-state, fetch T1–T3 plus execute T4–T6, from the IR opcode.
- Supports run/program gating, a single-step debug mode and latched halt.
- Drives the shared bus enables so that at most one source is enabled in any cycle.

Parameters:
- FAST_RETIRE, 0: when 1, the sequencer returns to T1 right after the last non-NOP execute state instead of padding to T6.
- STEP_EN, 1: when 0, the single-step logic is removed and step_mode is ignored.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = execute, 0 = program/idle mode (RAM being loaded).
- step_mode  in  1  1 = advance one T-state per step pulse.
- step  in  1  raw step button, level input.
- instruction  in  4  IR opcode; valid from T4.
- cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo  out  1 each  control word bits, registered.
- hlt  out  1  halt flag, latched.
- t_state  out  3  0 = IDLE/HALT, 1..6 = T1..T6.
- instr_retired  out  8  count of completed instructions; wraps at 255→0.

Behaviour:
- Reset:
  - state IDLE, all control bits 0, hlt 0, t_state 0, instr_retired 0, step edge detector cleared.
  - Reset mid-instruction aborts the instruction on that edge and does not retire it.
- States: IDLE, T1..T6, HALT. All outputs are registered from the next state, so the control word matches t_state in the same cycle.
- IDLE → T1 on the first edge with run=1. The control word is all zero in IDLE.
- run=0 while in T1..T6: the current instruction completes, then the sequencer goes to IDLE instead of T1.
- Fetch:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute by opcode, sampled in T4 and in later states:
  - LDA 0000: T4 ei,lm; T5 ce,la; T6 none.
  - ADD 0001: T4 ei,lm; T5 ce,lb; T6 eu,la.
  - SUB 0010: T4 ei,lm; T5 ce,lb; T6 eu,la,su.
  - OUT 1110: T4 ea,lo; T5 none; T6 none.
  - HLT 1111: T4 hlt=1 with all other bits 0; the next state is HALT.
  - Any other opcode: NOP for T4–T6.
- FAST_RETIRE=1: LDA retires after T5; OUT and NOP opcodes retire after T4. ADD and SUB always use T6.
- Retire:
  - instr_retired increments on the edge leaving the final execute state.
  - HLT does not count.
- HALT:
  - hlt stays 1 and all other bits stay 0.
  - Only reset leaves HALT; run and step are ignored.
- Single step (STEP_EN=1, step_mode=1):
  - step is synchronised by 2 flops, then rising-edge detected.
  - The state advances only on a detected edge; otherwise the state and control word hold.
  - One button press advances exactly one T-state, however long it is held.
  - Toggling step_mode mid-instruction takes effect on the next edge without losing state.
- Bus invariant: at most one of ep, ce, ei, ea, eu is 1 in any cycle. This is a required assertion.
- cp is 1 for exactly one cycle per instruction, or one step in step mode.

Decomposition:
- Shared package sap_pkg holds:
  - the opcode constants (LDA, ADD, SUB, OUT, HLT);
  - the T-state enumeration (IDLE=0, T1..T6=1..6, HALT=7);
  - the control-word bit index constants and the control-word typedef.
- One sub-module, sap_step_sync: 2-flop synchroniser plus rising-edge pulse generator with synchronous reset.
- The sequencer state machine and the control decode stay in sap_microsequencer.

Test Plan:
- Reset then run=1 with instruction=0000 (LDA):
  - t_state goes 1,2,3,4,5,6,1.
  - The control words are {ep,lm}, {cp}, {ce,li}, {ei,lm}, {ce,la}, {}.
  - instr_retired goes 0→1.
- ADD then SUB back to back:
  - ADD T6 gives eu,la with su=0; SUB T6 gives eu,la,su.
  - The bus one-hot assertion is never violated.
  - instr_retired=2.
- OUT with FAST_RETIRE=1: T4 ea,lo, then T1 on the next cycle.
- HLT (1111):
  - T4 asserts hlt, then HALT.
  - 20 cycles with run and step toggling keep hlt=1, t_state=7, other bits 0.
  - A 1-cycle reset returns to IDLE with hlt=0.
- Step mode:
  - step_mode=1, step held high for 10 cycles: exactly one T-state advance.
  - Five step pulses from IDLE with run=1 reach T5; with no pulses the state holds.
- Run drop and reset abort:
  - run=0 during T2 of LDA: the instruction completes through T6, then IDLE and the counter increments.
  - Separately, reset asserted in T5: IDLE on the next edge and the counter is unchanged.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, T-state encoding and control-word layout for the SAP-1 sequencer
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } t_state_e;

   localparam int CW_W  = 12;
   localparam int CW_CP = 11;
   localparam int CW_EP = 10;
   localparam int CW_LM = 9;
   localparam int CW_CE = 8;
   localparam int CW_LI = 7;
   localparam int CW_EI = 6;
   localparam int CW_LA = 5;
   localparam int CW_EA = 4;
   localparam int CW_SU = 3;
   localparam int CW_EU = 2;
   localparam int CW_LB = 1;
   localparam int CW_LO = 0;

   typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_step_sync.sv
// rtl/sap_step_sync.sv - two-flop synchroniser and rising-edge pulse for the step button
module sap_step_sync (
   input  logic clock,
   input  logic reset,
   input  logic i_step,
   output logic o_step_pulse
);

   logic r_sync0;
   logic r_sync1;
   logic r_prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync0 <= i_step;
         r_sync1 <= r_sync0;
         r_prev  <= r_sync1;
      end
   end

   assign o_step_pulse = r_sync1 & ~r_prev;

endmodule

// File: rtl/sap_microsequencer.sv
// rtl/sap_microsequencer.sv - SAP-1 ring-counter control sequencer with step mode and latched halt
module sap_microsequencer
   import sap_pkg::*;
#(
   parameter int FAST_RETIRE = 0,
   parameter int STEP_EN     = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic       step_mode,
   input  logic       step,
   input  logic [3:0] instruction,
   output logic       cp,
   output logic       ep,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       ei,
   output logic       la,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb,
   output logic       lo,
   output logic       hlt,
   output logic [2:0] t_state,
   output logic [7:0] instr_retired
);

   t_state_e   r_state;
   t_state_e   w_next;
   ctrl_word_t r_ctrl;
   ctrl_word_t w_ctrl;
   logic       r_hlt;
   logic       w_hlt;
   logic [7:0] r_retired;
   logic       w_step_pulse;
   logic       w_adv;
   logic       w_last;
   logic       w_retire;

   generate
      if (STEP_EN != 0) begin : g_step
         sap_step_sync u_step_sync (
            .clock        (clock),
            .reset        (reset),
            .i_step       (step),
            .o_step_pulse (w_step_pulse)
         );
      end else begin : g_no_step
         assign w_step_pulse = 1'b0;
      end
   endgenerate

   assign w_adv = (STEP_EN == 0) || !step_mode || w_step_pulse;

   // Final execute state of the current opcode; T6 always ends an instruction.
   always_comb begin
      w_last = (r_state == S_T6);
      if (FAST_RETIRE != 0) begin
         case (instruction)
            OP_LDA:         w_last = w_last || (r_state == S_T5);
            OP_ADD, OP_SUB: w_last = w_last;
            default:        w_last = w_last || (r_state == S_T4);
         endcase
      end
   end

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      if (w_adv) begin
         case (r_state)
            S_IDLE: if (run) w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_T3:   w_next = S_T4;
            S_T4, S_T5, S_T6: begin
               if (r_state == S_T4 && instruction == OP_HLT) begin
                  w_next = S_HALT;
               end else if (w_last) begin
                  w_next   = run ? S_T1 : S_IDLE;
                  w_retire = 1'b1;
               end else begin
                  w_next = (r_state == S_T4) ? S_T5 : S_T6;
               end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Decoding from the next state lets the registered word line up with t_state.
   always_comb begin
      w_ctrl = '0;
      w_hlt  = 1'b0;
      case (w_next)
         S_T1: begin
            w_ctrl[CW_EP] = 1'b1;
            w_ctrl[CW_LM] = 1'b1;
         end
         S_T2: w_ctrl[CW_CP] = 1'b1;
         S_T3: begin
            w_ctrl[CW_CE] = 1'b1;
            w_ctrl[CW_LI] = 1'b1;
         end
         S_T4: begin
            case (instruction)
               OP_LDA, OP_ADD, OP_SUB: begin
                  w_ctrl[CW_EI] = 1'b1;
                  w_ctrl[CW_LM] = 1'b1;
               end
               OP_OUT: begin
                  w_ctrl[CW_EA] = 1'b1;
                  w_ctrl[CW_LO] = 1'b1;
               end
               OP_HLT:  w_hlt = 1'b1;
               default: w_ctrl = '0;
            endcase
         end
         S_T5: begin
            case (instruction)
               OP_LDA: begin
                  w_ctrl[CW_CE] = 1'b1;
                  w_ctrl[CW_LA] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w_ctrl[CW_CE] = 1'b1;
                  w_ctrl[CW_LB] = 1'b1;
               end
               default: w_ctrl = '0;
            endcase
         end
         S_T6: begin
            if (instruction == OP_ADD || instruction == OP_SUB) begin
               w_ctrl[CW_EU] = 1'b1;
               w_ctrl[CW_LA] = 1'b1;
               w_ctrl[CW_SU] = (instruction == OP_SUB);
            end
         end
         S_HALT: w_hlt = 1'b1;
         default: w_ctrl = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ctrl    <= '0;
         r_hlt     <= 1'b0;
         r_retired <= 8'd0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= w_ctrl;
         r_hlt   <= w_hlt;
         if (w_retire) r_retired <= r_retired + 8'd1;
      end
   end

   a_bus_onehot: assert property (@(posedge clock) disable iff (reset)
      $onehot0({r_ctrl[CW_EP], r_ctrl[CW_CE], r_ctrl[CW_EI], r_ctrl[CW_EA], r_ctrl[CW_EU]}));

   assign cp            = r_ctrl[CW_CP];
   assign ep            = r_ctrl[CW_EP];
   assign lm            = r_ctrl[CW_LM];
   assign ce            = r_ctrl[CW_CE];
   assign li            = r_ctrl[CW_LI];
   assign ei            = r_ctrl[CW_EI];
   assign la            = r_ctrl[CW_LA];
   assign ea            = r_ctrl[CW_EA];
   assign su            = r_ctrl[CW_SU];
   assign eu            = r_ctrl[CW_EU];
   assign lb            = r_ctrl[CW_LB];
   assign lo            = r_ctrl[CW_LO];
   assign hlt           = r_hlt;
   assign t_state       = r_state;
   assign instr_retired = r_retired;

endmodule

// File: tb/tb_sap_microsequencer.sv
// tb/tb_sap_microsequencer.sv - random and directed checks of both retire variants against a T-state model
module tb_sap_microsequencer;

   localparam logic [11:0] K_CP = 12'h800, K_EP = 12'h400, K_LM = 12'h200, K_CE = 12'h100;
   localparam logic [11:0] K_LI = 12'h080, K_EI = 12'h040, K_LA = 12'h020, K_EA = 12'h010;
   localparam logic [11:0] K_SU = 12'h008, K_EU = 12'h004, K_LB = 12'h002, K_LO = 12'h001;
   localparam logic [11:0] K_BUS = K_EP | K_CE | K_EI | K_EA | K_EU;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b0;
   logic step_mode = 1'b0;
   logic step = 1'b0;
   logic [3:0] instruction = 4'h0;

   logic [1:0][11:0] cw_o;
   logic [1:0]       hl_o;
   logic [1:0][2:0]  ts_o;
   logic [1:0][7:0]  rt_o;

   int n_checks = 0;
   int n_fail = 0;
   int m_pos [2];
   int m_ret [2];
   logic q1 = 1'b0, q2 = 1'b0, q3 = 1'b0;

   always #5 clock = ~clock;

   sap_microsequencer #(.FAST_RETIRE(0), .STEP_EN(1)) u_dut_n (
      .clock(clock), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
      .instruction(instruction),
      .cp(cw_o[0][11]), .ep(cw_o[0][10]), .lm(cw_o[0][9]), .ce(cw_o[0][8]),
      .li(cw_o[0][7]), .ei(cw_o[0][6]), .la(cw_o[0][5]), .ea(cw_o[0][4]),
      .su(cw_o[0][3]), .eu(cw_o[0][2]), .lb(cw_o[0][1]), .lo(cw_o[0][0]),
      .hlt(hl_o[0]), .t_state(ts_o[0]), .instr_retired(rt_o[0])
   );

   sap_microsequencer #(.FAST_RETIRE(1), .STEP_EN(1)) u_dut_f (
      .clock(clock), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
      .instruction(instruction),
      .cp(cw_o[1][11]), .ep(cw_o[1][10]), .lm(cw_o[1][9]), .ce(cw_o[1][8]),
      .li(cw_o[1][7]), .ei(cw_o[1][6]), .la(cw_o[1][5]), .ea(cw_o[1][4]),
      .su(cw_o[1][3]), .eu(cw_o[1][2]), .lb(cw_o[1][1]), .lo(cw_o[1][0]),
      .hlt(hl_o[1]), .t_state(ts_o[1]), .instr_retired(rt_o[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Number of T-states an opcode occupies before returning to T1.
   function automatic int instr_len(input logic [3:0] op, input bit fast);
      if (!fast) return 6;
      if (op == 4'h0) return 5;
      if (op == 4'h1 || op == 4'h2) return 6;
      return 4;
   endfunction

   function automatic logic [11:0] exp_cw(input int pos, input logic [3:0] op);
      case (pos)
         1: return K_EP | K_LM;
         2: return K_CP;
         3: return K_CE | K_LI;
         4: begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) return K_EI | K_LM;
            if (op == 4'hE) return K_EA | K_LO;
            return 12'h000;
         end
         5: begin
            if (op == 4'h0) return K_CE | K_LA;
            if (op == 4'h1 || op == 4'h2) return K_CE | K_LB;
            return 12'h000;
         end
         6: begin
            if (op == 4'h1) return K_EU | K_LA;
            if (op == 4'h2) return K_EU | K_LA | K_SU;
            return 12'h000;
         end
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [3:0] rand_op();
      case ($urandom_range(0, 4))
         0: return 4'h0;
         1: return 4'h1;
         2: return 4'h2;
         3: return 4'hE;
         default: return 4'($urandom_range(3, 13));
      endcase
   endfunction

   task automatic model_edge();
      logic adv;
      adv = !step_mode || (q2 && !q3);
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            m_pos[d] = 0;
            m_ret[d] = 0;
         end else if (adv) begin
            if (m_pos[d] == 0) begin
               if (run) m_pos[d] = 1;
            end else if (m_pos[d] <= 3) begin
               m_pos[d] = m_pos[d] + 1;
            end else if (m_pos[d] <= 6) begin
               if (m_pos[d] == 4 && instruction == 4'hF) m_pos[d] = 7;
               else if (m_pos[d] == instr_len(instruction, d == 1)) begin
                  m_ret[d] = (m_ret[d] + 1) % 256;
                  m_pos[d] = run ? 1 : 0;
               end else m_pos[d] = m_pos[d] + 1;
            end
         end
      end
      if (reset) begin
         q1 = 1'b0; q2 = 1'b0; q3 = 1'b0;
      end else begin
         q3 = q2; q2 = q1; q1 = step;
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         model_edge();
         @(posedge clock);
         #1;
         for (int d = 0; d < 2; d++) begin
            check_eq(d ? "t_state_f" : "t_state_n", 32'(ts_o[d]), 32'(m_pos[d]));
            check_eq(d ? "ctrl_f" : "ctrl_n", 32'(cw_o[d]), 32'(exp_cw(m_pos[d], instruction)));
            check_eq(d ? "hlt_f" : "hlt_n", 32'(hl_o[d]),
                     32'(m_pos[d] == 7 || (m_pos[d] == 4 && instruction == 4'hF)));
            check_eq(d ? "retired_f" : "retired_n", 32'(rt_o[d]), 32'(m_ret[d]));
            check_eq(d ? "bus_onehot_f" : "bus_onehot_n", 32'($countones(cw_o[d] & K_BUS) <= 1), 32'd1);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(1);
      reset = 1'b0;
   endtask

   task automatic drain();
      run = 1'b0;
      step_mode = 1'b0;
      for (int k = 0; k < 20 && !(m_pos[0] == 0 && m_pos[1] == 0); k++) cycle(1);
      check_eq("drain_idle", 32'({ts_o[1], ts_o[0]}), 32'd0);
   endtask

   initial begin
      do_reset();
      check_eq("reset_ctrl", 32'({cw_o[1], cw_o[0]}), 32'd0);
      check_eq("reset_state", 32'({ts_o[1], ts_o[0], hl_o}), 32'd0);

      instruction = 4'h0;
      cycle(2);
      run = 1'b1;
      cycle(7);
      check_eq("lda_ts_n", 32'(ts_o[0]), 32'd1);
      check_eq("lda_ret_n", 32'(rt_o[0]), 32'd1);
      check_eq("lda_ts_f", 32'(ts_o[1]), 32'd2);
      drain();

      do_reset();
      instruction = 4'h1;
      run = 1'b1;
      cycle(6);
      check_eq("add_t6", 32'(cw_o[0]), 32'(K_EU | K_LA));
      instruction = 4'h2;
      cycle(6);
      check_eq("sub_t6", 32'(cw_o[0]), 32'(K_EU | K_LA | K_SU));
      cycle(1);
      check_eq("addsub_ret", 32'(rt_o[0]), 32'd2);
      drain();

      do_reset();
      instruction = 4'hE;
      run = 1'b1;
      cycle(4);
      check_eq("out_t4_f", 32'(cw_o[1]), 32'(K_EA | K_LO));
      cycle(1);
      check_eq("out_fast_t1", 32'(ts_o[1]), 32'd1);
      check_eq("out_fast_ret", 32'(rt_o[1]), 32'd1);
      drain();

      do_reset();
      step_mode = 1'b1;
      run = 1'b1;
      instruction = 4'h0;
      step = 1'b1;
      cycle(10);
      check_eq("step_held", 32'(ts_o[0]), 32'd1);
      step = 1'b0;
      cycle(5);
      repeat (4) begin
         step = 1'b1;
         cycle(2);
         step = 1'b0;
         cycle(3);
      end
      check_eq("step_t5", 32'(ts_o[0]), 32'd5);
      cycle(5);
      check_eq("step_hold", 32'(ts_o[0]), 32'd5);
      drain();

      do_reset();
      instruction = 4'h0;
      run = 1'b1;
      cycle(2);
      run = 1'b0;
      cycle(5);
      check_eq("rundrop_idle", 32'(ts_o[0]), 32'd0);
      check_eq("rundrop_ret", 32'(rt_o[0]), 32'd1);

      run = 1'b1;
      cycle(5);
      check_eq("abort_t5", 32'(ts_o[0]), 32'd5);
      do_reset();
      check_eq("abort_idle", 32'(ts_o[0]), 32'd0);
      check_eq("abort_ret", 32'(rt_o[0]), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
         step = ($urandom_range(0, 2) == 0);
         if (m_pos[0] <= 3 && m_pos[1] <= 3 && $urandom_range(0, 3) == 0) instruction = rand_op();
         cycle(1);
      end
      reset = 1'b0;
      drain();

      do_reset();
      instruction = 4'hF;
      run = 1'b1;
      cycle(4);
      check_eq("hlt_t4", 32'({hl_o[0], ts_o[0]}), 32'h0C);
      cycle(1);
      check_eq("halt_state", 32'(ts_o[0]), 32'd7);
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom_range(0, 1));
         step = 1'($urandom_range(0, 1));
         step_mode = 1'($urandom_range(0, 1));
         cycle(1);
      end
      check_eq("halt_stuck", 32'({hl_o, ts_o[1], ts_o[0]}), 32'hFF);
      check_eq("halt_ctrl", 32'({cw_o[1], cw_o[0]}), 32'd0);
      run = 1'b0;
      do_reset();
      check_eq("halt_reset", 32'({hl_o, ts_o[1], ts_o[0]}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
